// File: rtl/sprite_motion.sv
// sprite_motion
// Per-frame motion controller for one playfield sprite. Horizontal walking
// wraps or clamps at the screen edges. Vertical motion uses a velocity with
// gravity, a terminal speed and a limited number of jumps per airborne
// period. Origin, facing and status flags are registered for the renderer.
module sprite_motion #(
  parameter int CORDW     = 16,
  parameter int H_RES     = 800,
  parameter int V_RES     = 600,
  parameter int SPR_W_PX  = 38,
  parameter int SPR_H_PX  = 54,
  parameter int WRAP_X    = 1,
  parameter int MARGIN    = 150,
  parameter int MAX_JUMPS = 2,
  parameter int GRAVITY   = 1,
  parameter int VMAX      = 15,
  parameter int START_X   = 100,
  parameter int START_Y   = -200
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic [5:0]              i_ctrl,
  input  logic [7:0]              i_speed,
  input  logic [7:0]              i_jump_v,
  input  logic signed [CORDW-1:0] i_floor,
  output logic signed [CORDW-1:0] o_sprx,
  output logic signed [CORDW-1:0] o_spry,
  output logic signed [CORDW-1:0] o_vy,
  output logic                    o_face_left,
  output logic                    o_walking,
  output logic                    o_jumping,
  output logic                    o_landed,
  output logic [2:0]              o_jumps_left
);

  // One guard bit above the coordinate width so edge compares cannot overflow.
  localparam int SW = CORDW + 1;

  localparam logic signed [SW-1:0]    X_WRAP_HI  = SW'(H_RES + MARGIN);
  localparam logic signed [SW-1:0]    X_WRAP_LO  = SW'(-MARGIN);
  localparam logic signed [SW-1:0]    X_CLAMP_HI = SW'(H_RES - SPR_W_PX);
  localparam logic signed [SW-1:0]    V_RES_W    = SW'(V_RES);
  localparam logic signed [SW-1:0]    SPR_H_W    = SW'(SPR_H_PX);
  localparam logic signed [SW-1:0]    GRAV_W     = SW'(GRAVITY);
  localparam logic signed [SW-1:0]    VMAX_W     = SW'(VMAX);
  localparam logic signed [CORDW-1:0] X_ENTER_L  = CORDW'(-SPR_W_PX);
  localparam logic signed [CORDW-1:0] X_ENTER_R  = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] X_RST      = CORDW'(START_X);
  localparam logic signed [CORDW-1:0] Y_RST      = CORDW'(START_Y);
  localparam logic [2:0]              JUMPS_MAX  = 3'(MAX_JUMPS);
  localparam logic [2:0]              JUMPS_AIR  = 3'(MAX_JUMPS - 1);

  typedef enum logic [1:0] {X_IDLE = 2'd0, X_LEFT = 2'd1, X_RIGHT = 2'd2} x_state_t;
  typedef enum logic [1:0] {Y_GROUND = 2'd0, Y_RISE = 2'd1, Y_FALL = 2'd2} y_state_t;

  x_state_t x_state_r, x_state_n;
  y_state_t y_state_r, y_state_n;

  logic signed [CORDW-1:0] x_r, y_r, vy_r;
  logic signed [CORDW-1:0] x_n_s, y_n_s, vy_n_s;
  logic [2:0]              jumps_r, jumps_n_s;
  logic                    face_r, face_n_s;
  logic                    walking_r, jumping_r, landed_r, land_s;
  logic                    jprev_r, jreq_r, jedge_s, jr_s;

  logic signed [SW-1:0] speed_s, jump_v_s, x_ext_s, y_ext_s, vy_ext_s, floor_ext_s;
  logic signed [SW-1:0] x_right_s, x_left_s, yf_s, y_cont_s;
  logic signed [SW-1:0] vy_grav_s, vy_cap_s, y_jump_s, vy_jump_s;
  logic                 unused_s;

  assign speed_s     = {{(SW-8){1'b0}}, i_speed};
  assign jump_v_s    = {{(SW-8){1'b0}}, i_jump_v};
  assign x_ext_s     = {x_r[CORDW-1], x_r};
  assign y_ext_s     = {y_r[CORDW-1], y_r};
  assign vy_ext_s    = {vy_r[CORDW-1], vy_r};
  assign floor_ext_s = {i_floor[CORDW-1], i_floor};

  assign x_right_s = x_ext_s + speed_s;
  assign x_left_s  = x_ext_s - speed_s;
  assign yf_s      = V_RES_W - floor_ext_s - SPR_H_W;
  assign y_cont_s  = y_ext_s + vy_ext_s;
  assign vy_grav_s = vy_ext_s + GRAV_W;
  assign vy_cap_s  = (vy_grav_s > VMAX_W) ? VMAX_W : vy_grav_s;
  assign y_jump_s  = y_ext_s - jump_v_s;
  assign vy_jump_s = GRAV_W - jump_v_s;

  // A press only counts on its rising edge; a press in the frame cycle itself is honoured.
  assign jedge_s = i_ctrl[4] & ~jprev_r;
  assign jr_s    = jreq_r | jedge_s;

  // Ignored controller bits and guard bits that are dropped on truncation.
  assign unused_s = ^{i_ctrl[5], i_ctrl[3:2], y_jump_s[SW-1], x_right_s[SW-1],
                      x_left_s[SW-1], y_cont_s[SW-1], vy_cap_s[SW-1]};

  // X state register follows the buttons every cycle; walking lags it by one cycle.
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_state_r <= X_IDLE;
      walking_r <= 1'b0;
    end else begin
      x_state_r <= x_state_n;
      walking_r <= (x_state_r != X_IDLE);
    end
  end

  // X next state: right wins when both directions are held.
  always_comb begin
    x_state_n = X_IDLE;
    if (i_ctrl[0]) begin
      x_state_n = X_RIGHT;
    end else if (i_ctrl[1]) begin
      x_state_n = X_LEFT;
    end else begin
      x_state_n = X_IDLE;
    end
  end

  // X outputs: candidate position and facing for the next frame.
  always_comb begin
    x_n_s    = x_r;
    face_n_s = face_r;
    case (x_state_r)
      X_RIGHT: begin
        face_n_s = 1'b0;
        if (WRAP_X != 32'sd0) begin
          if (x_right_s > X_WRAP_HI) x_n_s = X_ENTER_L;
          else                       x_n_s = x_right_s[CORDW-1:0];
        end else begin
          if (x_right_s > X_CLAMP_HI) x_n_s = X_CLAMP_HI[CORDW-1:0];
          else                        x_n_s = x_right_s[CORDW-1:0];
        end
      end
      X_LEFT: begin
        face_n_s = 1'b1;
        if (WRAP_X != 32'sd0) begin
          if (x_left_s < X_WRAP_LO) x_n_s = X_ENTER_R;
          else                      x_n_s = x_left_s[CORDW-1:0];
        end else begin
          if (x_left_s[SW-1]) x_n_s = {CORDW{1'b0}};
          else                x_n_s = x_left_s[CORDW-1:0];
        end
      end
      default: begin
        x_n_s    = x_r;
        face_n_s = face_r;
      end
    endcase
  end

  // Y next state and motion: a jump overrides everything, else ground tracking or flight.
  always_comb begin
    y_n_s     = y_r;
    vy_n_s    = vy_r;
    jumps_n_s = jumps_r;
    y_state_n = y_state_r;
    land_s    = 1'b0;
    if (jr_s && (jumps_r != 3'd0)) begin
      y_n_s     = y_jump_s[CORDW-1:0];
      vy_n_s    = vy_jump_s[CORDW-1:0];
      jumps_n_s = jumps_r - 3'd1;
      y_state_n = vy_jump_s[SW-1] ? Y_RISE : Y_FALL;
    end else begin
      case (y_state_r)
        Y_GROUND: begin
          vy_n_s = {CORDW{1'b0}};
          if (y_ext_s < yf_s) begin
            // Floor dropped away: start falling with one jump already spent.
            y_state_n = Y_FALL;
            jumps_n_s = JUMPS_AIR;
          end else begin
            y_n_s     = yf_s[CORDW-1:0];
            jumps_n_s = JUMPS_MAX;
          end
        end
        Y_RISE, Y_FALL: begin
          if (y_cont_s >= yf_s) begin
            y_n_s     = yf_s[CORDW-1:0];
            vy_n_s    = {CORDW{1'b0}};
            y_state_n = Y_GROUND;
            jumps_n_s = JUMPS_MAX;
            land_s    = 1'b1;
          end else begin
            y_n_s     = y_cont_s[CORDW-1:0];
            vy_n_s    = vy_cap_s[CORDW-1:0];
            y_state_n = vy_cap_s[SW-1] ? Y_RISE : Y_FALL;
          end
        end
        default: begin
          y_state_n = Y_FALL;
        end
      endcase
    end
  end

  // Frame update: commit position, velocity, Y state and the landing pulse.
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_r       <= X_RST;
      y_r       <= Y_RST;
      vy_r      <= {CORDW{1'b0}};
      face_r    <= 1'b0;
      jumps_r   <= 3'd0;
      y_state_r <= Y_FALL;
      jumping_r <= 1'b1;
      landed_r  <= 1'b0;
    end else begin
      landed_r <= i_frame & land_s;
      if (i_frame) begin
        x_r       <= x_n_s;
        y_r       <= y_n_s;
        vy_r      <= vy_n_s;
        face_r    <= face_n_s;
        jumps_r   <= jumps_n_s;
        y_state_r <= y_state_n;
        jumping_r <= (y_state_n != Y_GROUND);
      end
    end
  end

  // Jump request capture: sticky until the next frame consumes or drops it.
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      jprev_r <= 1'b0;
      jreq_r  <= 1'b0;
    end else begin
      jprev_r <= i_ctrl[4];
      if (i_frame)      jreq_r <= 1'b0;
      else if (jedge_s) jreq_r <= 1'b1;
    end
  end

  assign o_sprx       = x_r;
  assign o_spry       = y_r;
  assign o_vy         = vy_r;
  assign o_face_left  = face_r;
  assign o_walking    = walking_r;
  assign o_jumping    = jumping_r;
  assign o_landed     = landed_r;
  assign o_jumps_left = jumps_r;

endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion
// Directed bench for sprite_motion. Two instances share the stimulus: one
// wraps at the horizontal edges, the other clamps. Each frame strobe pushes
// its hand-computed expectation; a monitor pops and compares after the edge.
module tb_sprite_motion;

  typedef struct {
    string name;
    bit    cx; int xw; int xc;
    bit    cy; int y;  int vy;
    bit    cj; int jl;
    bit    cl; int ld;
    bit    cf; int fc;
  } exp_t;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              frame   = 1'b0;
  logic [5:0]        ctrl    = 6'd0;
  logic [7:0]        speed   = 8'd0;
  logic [7:0]        jump_v  = 8'd10;
  logic signed [15:0] floor_h = 16'sd0;

  logic signed [15:0] xw, yw, vyw;
  logic               facew, walkw, jumpw, landw;
  logic [2:0]         jlw;
  logic signed [15:0] xc, unused_c_y, unused_c_vy;
  logic               unused_c_face, unused_c_walk, unused_c_jump, unused_c_land;
  logic [2:0]         unused_c_jl;

  int   checks   = 0;
  int   errors   = 0;
  int   land_cnt = 0;
  logic fired    = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  // Single jump from the ground with jump_v = 10: y and vy per frame 1..21.
  int ya[21] = '{536, 527, 519, 512, 506, 501, 497, 494, 492, 491, 491,
                 492, 494, 497, 501, 506, 512, 519, 527, 536, 546};
  int va[21] = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, 0, 1,
                 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
  // Second jump at the apex (frame 11) through landing on frame 36.
  int yb[26] = '{481, 472, 464, 457, 451, 446, 442, 439, 437, 436, 436, 437, 439,
                 442, 446, 451, 457, 464, 472, 481, 491, 502, 514, 527, 541, 546};
  int vb[26] = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3,
                 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0};
  // Horizontal steps: speed, direction bits, wrap x, clamp x, facing.
  int sps[15] = '{45, 200, 200, 200, 200, 10, 10, 10, 10, 100, 100, 255, 255, 255, 255};
  int dirs[15] = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 2, 2, 2, 2, 2, 0};
  int xws[15] = '{145, 345, 545, 745, 945, -38, -48, -58, -48, -148, 800, 545, 290, 35, 35};
  int xcs[15] = '{145, 345, 545, 745, 762, 762, 752, 742, 752, 652, 552, 297, 42, 0, 0};
  int fcs[15] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

  sprite_motion dut_w (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_ctrl(ctrl),
    .i_speed(speed), .i_jump_v(jump_v), .i_floor(floor_h),
    .o_sprx(xw), .o_spry(yw), .o_vy(vyw), .o_face_left(facew),
    .o_walking(walkw), .o_jumping(jumpw), .o_landed(landw), .o_jumps_left(jlw)
  );

  sprite_motion #(.WRAP_X(0)) dut_c (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_ctrl(ctrl),
    .i_speed(speed), .i_jump_v(jump_v), .i_floor(floor_h),
    .o_sprx(xc), .o_spry(unused_c_y), .o_vy(unused_c_vy), .o_face_left(unused_c_face),
    .o_walking(unused_c_walk), .o_jumping(unused_c_jump), .o_landed(unused_c_land),
    .o_jumps_left(unused_c_jl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm);
    exp_t e;
    e.name = nm;
    e.cx = 1'b0; e.xw = 0; e.xc = 0;
    e.cy = 1'b0; e.y = 0; e.vy = 0;
    e.cj = 1'b0; e.jl = 0;
    e.cl = 1'b0; e.ld = 0;
    e.cf = 1'b0; e.fc = 0;
    return e;
  endfunction

  // One frame strobe; optionally raise jump in the very same cycle.
  task automatic run_frame(input exp_t e, input bit jset);
    @(negedge clk);
    frame = 1'b1;
    if (jset) ctrl[4] = 1'b1;
    q.push_back(e);
    @(negedge clk);
    frame = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle jump press between frames; relies on the sticky request.
  task automatic pulse_jump();
    ctrl[4] = 1'b1;
    @(negedge clk);
    ctrl[4] = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " x wrap"}, xw, 100);
    chk({tag, " x clamp"}, xc, 100);
    chk({tag, " y"}, yw, -200);
    chk({tag, " vy"}, vyw, 0);
    chk({tag, " face"}, facew, 0);
    chk({tag, " jumps_left"}, jlw, 0);
    chk({tag, " landed"}, landw, 0);
    chk({tag, " walking"}, walkw, 0);
    chk({tag, " jumping"}, jumpw, 1);
  endtask

  // Remember which edges were frame edges.
  always @(posedge clk) fired <= frame;

  // Count landing pulse cycles.
  always @(negedge clk) if (landw === 1'b1) land_cnt++;

  // Scoreboard monitor: every frame edge produces one output set to compare.
  always @(negedge clk) begin
    if (fired === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got frame output, expected none pending");
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cx) begin
          chk($sformatf("%s x wrap", mon_e.name), xw, mon_e.xw);
          chk($sformatf("%s x clamp", mon_e.name), xc, mon_e.xc);
        end
        if (mon_e.cy) begin
          chk($sformatf("%s y", mon_e.name), yw, mon_e.y);
          chk($sformatf("%s vy", mon_e.name), vyw, mon_e.vy);
        end
        if (mon_e.cj) chk($sformatf("%s jumps_left", mon_e.name), jlw, mon_e.jl);
        if (mon_e.cl) chk($sformatf("%s landed", mon_e.name), landw, mon_e.ld);
        if (mon_e.cf) chk($sformatf("%s face", mon_e.name), facew, mon_e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   base;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Free fall from reset onto the floor.
    base = land_cnt;
    for (int k = 1; k <= 60; k++) begin
      e = mk($sformatf("fall f%0d", k));
      if (k == 1) begin
        e.cy = 1'b1; e.y = -200; e.vy = 1; e.cj = 1'b1; e.jl = 0;
      end else if (k == 16) begin
        e.cy = 1'b1; e.y = -80; e.vy = 15;
      end else if (k == 57) begin
        e.cy = 1'b1; e.y = 535; e.vy = 15; e.cl = 1'b1; e.ld = 0;
      end else if (k == 58) begin
        e.cy = 1'b1; e.y = 546; e.vy = 0; e.cj = 1'b1; e.jl = 2; e.cl = 1'b1; e.ld = 1;
      end else if (k == 60) begin
        e.cy = 1'b1; e.y = 546; e.vy = 0; e.cj = 1'b1; e.jl = 2; e.cl = 1'b1; e.ld = 0;
      end
      run_frame(e, 1'b0);
    end
    chk("fall landing pulses", land_cnt - base, 1);
    chk("fall jumping", jumpw, 0);

    // Single jump, edge in the same cycle as the frame strobe.
    base = land_cnt;
    for (int k = 1; k <= 21; k++) begin
      e = mk($sformatf("jump f%0d", k));
      e.cy = 1'b1; e.y = ya[k-1]; e.vy = va[k-1];
      e.cj = 1'b1; e.jl = (k == 21) ? 2 : 1;
      if (k >= 20) begin e.cl = 1'b1; e.ld = (k == 21) ? 1 : 0; end
      run_frame(e, k == 1);
      if (k == 1) ctrl[4] = 1'b0;
    end
    chk("jump landing pulses", land_cnt - base, 1);

    // Double jump at the apex, a third press ignored, a press on landing dropped.
    for (int k = 1; k <= 36; k++) begin
      if (k == 11 || k == 12 || k == 36) pulse_jump();
      e = mk($sformatf("djump f%0d", k));
      e.cy = 1'b1; e.cj = 1'b1;
      if (k <= 10) begin
        e.y = ya[k-1]; e.vy = va[k-1]; e.jl = 1;
      end else begin
        e.y = yb[k-11]; e.vy = vb[k-11]; e.jl = (k == 36) ? 2 : 0;
      end
      if (k >= 35) begin e.cl = 1'b1; e.ld = (k == 36) ? 1 : 0; end
      run_frame(e, k == 1);
      if (k == 1) ctrl[4] = 1'b0;
    end

    // Jump held for 100 frames gives exactly one jump.
    base = land_cnt;
    for (int k = 1; k <= 100; k++) begin
      e = mk($sformatf("held f%0d", k));
      if (k == 1) begin
        e.cy = 1'b1; e.y = 536; e.vy = -9; e.cj = 1'b1; e.jl = 1;
      end else if (k == 21) begin
        e.cy = 1'b1; e.y = 546; e.vy = 0; e.cj = 1'b1; e.jl = 2; e.cl = 1'b1; e.ld = 1;
      end else if (k == 100) begin
        e.cy = 1'b1; e.y = 546; e.vy = 0; e.cj = 1'b1; e.jl = 2; e.cl = 1'b1; e.ld = 0;
      end
      run_frame(e, k == 1);
    end
    ctrl[4] = 1'b0;
    chk("held landing pulses", land_cnt - base, 1);

    // Horizontal walking: wrap vs clamp, both edges, both directions.
    for (int k = 0; k < 15; k++) begin
      ctrl[1:0] = 2'(dirs[k]);
      speed     = 8'(sps[k]);
      e = mk($sformatf("walk s%0d", k));
      e.cx = 1'b1; e.xw = xws[k]; e.xc = xcs[k];
      e.cf = 1'b1; e.fc = fcs[k];
      run_frame(e, 1'b0);
      if (k == 7) chk("walking left", walkw, 1);
    end
    chk("walking idle", walkw, 0);

    // Floor rises under a grounded sprite, then drops away.
    floor_h = 16'sd100;
    e = mk("floor up");
    e.cy = 1'b1; e.y = 446; e.vy = 0; e.cj = 1'b1; e.jl = 2;
    run_frame(e, 1'b0);
    chk("floor up jumping", jumpw, 0);
    floor_h = 16'sd0;
    e = mk("floor down");
    e.cy = 1'b1; e.y = 446; e.vy = 0; e.cj = 1'b1; e.jl = 1;
    run_frame(e, 1'b0);
    chk("floor down jumping", jumpw, 1);
    e = mk("floor fall");
    e.cy = 1'b1; e.y = 446; e.vy = 1; e.cj = 1'b1; e.jl = 1;
    run_frame(e, 1'b0);

    // Asynchronous reset in the middle of a jump while walking left.
    ctrl[1:0] = 2'd2;
    speed     = 8'd1;
    pulse_jump();
    e = mk("air jump");
    e.cy = 1'b1; e.y = 436; e.vy = -9; e.cj = 1'b1; e.jl = 0;
    run_frame(e, 1'b0);
    run_frame(mk("air"), 1'b0);
    chk("pre-reset walking", walkw, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async reset");
    ctrl = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    e = mk("after reset");
    e.cx = 1'b1; e.xw = 100; e.xc = 100;
    e.cy = 1'b1; e.y = -200; e.vy = 1; e.cj = 1'b1; e.jl = 0;
    run_frame(e, 1'b0);

    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Per-frame motion controller for one playfield sprite. It turns the controller bits into a registered sprite origin, facing and status flags, which feed the sprite renderer. It extends the single-jump, right-only mover with:
- bidirectional horizontal motion with selectable wrap or clamp at the screen edges;
- velocity-based vertical motion with gravity, a terminal velocity and N-jump (double-jump) support;
- jump edge detection and a landing pulse.

## Interface
Parameters:
- CORDW, 16: coordinate width; all coordinates are signed.
- H_RES, 800: visible width in pixels.
- V_RES, 600: visible height in pixels.
- SPR_W_PX, 38: scaled sprite width in pixels.
- SPR_H_PX, 54: scaled sprite height in pixels.
- WRAP_X, 1: 1 = wrap at the horizontal edges; 0 = clamp inside the screen.
- MARGIN, 150: off-screen distance before a wrap occurs.
- MAX_JUMPS, 2: jumps allowed per airborne period; range 1..7.
- GRAVITY, 1: added to vy every airborne frame.
- VMAX, 15: terminal downward velocity.
- START_X, 100: reset x.
- START_Y, -200: reset y.

Ports (clock and reset first):
- i_clk_pix, in, 1: pixel clock; the only clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_frame, in, 1: one-cycle strobe at frame start; every motion update happens on this cycle.
- i_ctrl, in, 6: [0] right, [1] left, [4] jump; other bits are ignored.
- i_speed, in, 8: horizontal pixels per frame, unsigned.
- i_jump_v, in, 8: initial upward speed, unsigned.
- i_floor, in, CORDW signed: floor height above the screen bottom.
- o_sprx, out, CORDW signed: sprite x origin.
- o_spry, out, CORDW signed: sprite y origin.
- o_vy, out, CORDW signed: vertical velocity; positive is downward.
- o_face_left, out, 1: 1 = facing left.
- o_walking, out, 1: x state is not IDLE.
- o_jumping, out, 1: y state is not GROUND.
- o_landed, out, 1: one-cycle pulse on touchdown.
- o_jumps_left, out, 3: remaining jumps.

## Operation
- Floor target: yf = V_RES − i_floor − SPR_H_PX, computed combinationally.
- Arithmetic: all sums are evaluated in CORDW+1 signed bits, with i_speed and i_jump_v zero-extended, then truncated after the compare.
- X FSM states: IDLE, LEFT, RIGHT.
  - Next state: i_ctrl[0] gives RIGHT (right has priority when both bits are set); else i_ctrl[1] gives LEFT; else IDLE.
  - The state register updates every cycle.
- X update on i_frame:
  - RIGHT: xn = x + speed.
    - Wrap mode: if xn > H_RES + MARGIN then x ← −SPR_W_PX, else x ← xn.
    - Clamp mode: x ← min(xn, H_RES − SPR_W_PX).
    - face ← 0.
  - LEFT: xn = x − speed.
    - Wrap mode: if xn < −MARGIN then x ← H_RES, else x ← xn.
    - Clamp mode: x ← max(xn, 0).
    - face ← 1.
  - IDLE: x and face hold.
- Jump request:
  - jprev registers i_ctrl[4] every cycle.
  - A rising edge (i_ctrl[4] & ~jprev) sets the sticky flag jreq.
  - Effective request jr = jreq | rising edge in the current cycle.
  - jreq clears on every i_frame, whether or not the request was honoured.
  - Holding the jump button never repeats a jump.
- Y FSM states: GROUND, RISE, FALL. Evaluated on i_frame, in priority order:
  1. Jump: jr and jumps_left > 0 (any state).
     - y ← y − i_jump_v; vy ← −i_jump_v + GRAVITY; jumps_left −1.
     - State ← RISE if the new vy < 0, else FALL.
  2. GROUND, no jump:
     - If y < yf (floor dropped away): state ← FALL, vy ← 0, jumps_left ← MAX_JUMPS−1.
     - Otherwise: y ← yf (tracks a rising floor), vy ← 0, jumps_left ← MAX_JUMPS.
  3. RISE/FALL, no jump: yc = y + vy.
     - If yc ≥ yf: y ← yf, vy ← 0, state ← GROUND, jumps_left ← MAX_JUMPS, o_landed pulses.
     - Otherwise: y ← yc, vy ← min(vy + GRAVITY, VMAX).
     - State ← RISE if the new vy < 0, else FALL.

## Timing
- Reset (asynchronous, active-low) values:
  - x = START_X, y = START_Y, vy = 0.
  - X state IDLE; Y state FALL.
  - face 0, jumps_left 0, jreq 0, jprev 0.
  - o_landed 0, o_walking 0, o_jumping 1.
- Reset takes effect immediately, including mid-jump; the first update after release happens on the next i_frame.
- Latency: every output is registered and changes on the clock edge where i_frame = 1, so it is visible the following cycle.
  - o_walking follows the X state with one cycle of latency, independent of i_frame.
- o_landed is high for exactly one i_clk_pix cycle, immediately after the landing frame edge.
- Simultaneous events:
  - A jump edge in the same cycle as i_frame is honoured in that frame.
  - A jump on the landing frame: in the air with jumps_left = 0, the jump is dropped and the sprite lands.
  - If the floor rises above an airborne sprite, the sprite snaps to yf as a landing.
- Between i_frame strobes, positions are stable; only jreq, jprev and the X state change.

## Test plan
- Reset, then 60 frames with no input, i_floor = 0 → y falls from −200 with vy capped at 15; lands at y = 546; o_landed pulses once; o_jumps_left = 2.
- On the ground, i_jump_v = 10, one jump edge → frame 1 y = 536; apex y = 491 after 10 frames; landing at y = 546 on frame 21, with o_landed pulsing on that frame.
- Second jump edge at the apex → accepted and jumps_left = 0; a third edge → ignored, and y keeps following gravity.
- Jump held high for 100 frames → exactly one jump occurs.
- WRAP_X = 1, x = 945, i_speed = 10, right held → x becomes −38 next frame.
- WRAP_X = 0, same stimulus → x = 762.
- Left held → x decrements by the speed each frame and o_face_left = 1.
- Both right and left held → RIGHT wins and o_face_left = 0.
- i_floor stepped from 0 to 100 while grounded → y snaps to 446 the next frame.
- i_floor stepped back to 0 → FALL with jumps_left = 1.
- i_rst_n asserted mid-jump → outputs return to their reset values asynchronously, before any clock edge.
